// File: rtl/hazard_fwd_unit_pkg.sv
// Shared definitions for the pipeline hazard / forwarding controller:
// operand-mux select encodings and the multi-cycle-op FSM state type.
package hazard_fwd_unit_pkg;

   // EX operand mux select encodings (one 2-bit field per source operand)
   localparam logic [1:0] FWD_REG = 2'b00;  // value read from the register file
   localparam logic [1:0] FWD_WB  = 2'b01;  // bypass from the WB-stage result
   localparam logic [1:0] FWD_MEM = 2'b10;  // bypass from the MEM-stage result

   // Multi-cycle EX op tracking: RUN = normal flow, MD_BUSY = mul/div occupying EX
   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } hz_state_t;

endpackage : hazard_fwd_unit_pkg

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-side bundle for the hazard controller. The pipeline (master)
// presents stage register fields; the controller (slave) returns operand
// selects, stall/bubble/flush enables and stall performance counters.
// id_valid qualifies every ID-stage field: when it is low the ID fields are
// don't-care and can never raise a load-use stall. There is no ready/backpressure
// path in this bundle; stalls are reported through the stall_* outputs.
interface hazard_fwd_unit_if #(
   parameter int REG_AW = 5,
   parameter int NSRC   = 2,
   parameter int PERF_W = 16
);

   // ID stage
   logic                   id_valid;
   logic [NSRC*REG_AW-1:0] id_rs;
   logic [NSRC-1:0]        id_rs_used;
   // EX stage
   logic [NSRC*REG_AW-1:0] ex_rs;
   logic [NSRC-1:0]        ex_imm_sel;
   logic [REG_AW-1:0]      ex_rd;
   logic                   ex_regwrite;
   logic                   ex_memread;
   logic                   ex_md_start;
   // MEM / WB stages
   logic [REG_AW-1:0]      mem_rd;
   logic                   mem_regwrite;
   logic [REG_AW-1:0]      wb_rd;
   logic                   wb_regwrite;
   // control flow
   logic                   redirect;

   // controller outputs
   logic [2*NSRC-1:0]      fwd_sel;
   logic [NSRC-1:0]        id_fwd_wb;
   logic                   stall_if;
   logic                   stall_id;
   logic                   stall_ex;
   logic                   bubble_ex;
   logic                   bubble_mem;
   logic                   flush_id;
   logic                   md_busy;
   logic [PERF_W-1:0]      ld_stall_cnt;
   logic [PERF_W-1:0]      md_stall_cnt;

   modport master (
      output id_valid, id_rs, id_rs_used,
      output ex_rs, ex_imm_sel, ex_rd, ex_regwrite, ex_memread, ex_md_start,
      output mem_rd, mem_regwrite, wb_rd, wb_regwrite, redirect,
      input  fwd_sel, id_fwd_wb, stall_if, stall_id, stall_ex,
      input  bubble_ex, bubble_mem, flush_id, md_busy,
      input  ld_stall_cnt, md_stall_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rs_used,
      input  ex_rs, ex_imm_sel, ex_rd, ex_regwrite, ex_memread, ex_md_start,
      input  mem_rd, mem_regwrite, wb_rd, wb_regwrite, redirect,
      output fwd_sel, id_fwd_wb, stall_if, stall_id, stall_ex,
      output bubble_ex, bubble_mem, flush_id, md_busy,
      output ld_stall_cnt, md_stall_cnt
   );

endinterface : hazard_fwd_unit_if

// File: rtl/hazard_fwd_unit_fwd_src_sel.sv
// Forward-select comparator for a single EX source operand. The MEM result
// is younger than the WB result, so a MEM match wins. x0 never forwards and
// an immediate operand never forwards.
module hazard_fwd_unit_fwd_src_sel
   import hazard_fwd_unit_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] ex_rs,
   input  logic              imm_sel,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwrite,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwrite,
   output logic [1:0]        sel
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs);
   assign wb_hit  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == ex_rs);

   // Priority pick: immediate blocks forwarding, then MEM, then WB
   always_comb begin
      sel = FWD_REG;
      if (!imm_sel) begin
         if (mem_hit) begin
            sel = FWD_MEM;
         end else if (wb_hit) begin
            sel = FWD_WB;
         end
      end
   end

endmodule : hazard_fwd_unit_fwd_src_sel

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard controller for the 5-stage core: EX operand forwarding for
// NSRC sources, ID-stage WB bypass, one-cycle load-use stall, a mul/div
// occupancy FSM, redirect flush and saturating stall performance counters.
// Stall/bubble/flush enables are combinational so they act in the same cycle
// as the condition that raises them; only the FSM and counters are registered.
module hazard_fwd_unit
   import hazard_fwd_unit_pkg::*;
#(
   parameter int REG_AW    = 5,
   parameter int NSRC      = 2,
   parameter int MD_LAT    = 4,
   parameter int WB_BYPASS = 1,
   parameter int PERF_W    = 16
) (
   input logic               clk,
   input logic               rst,
   hazard_fwd_unit_if.slave  hz
);

   // cnt counts the remaining stalled MD_BUSY cycles; the start cycle in RUN
   // and the final non-stalled MD_BUSY cycle make up the rest of MD_LAT.
   localparam int              CNT_W    = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_LAT - 2);

   hz_state_t         state;
   logic [CNT_W-1:0]  cnt;
   logic [PERF_W-1:0] ld_cnt;
   logic [PERF_W-1:0] md_cnt;

   logic [2*NSRC-1:0] fwd_raw;
   logic [NSRC-1:0]   id_wb_raw;
   logic              ld_src_hit;
   logic              load_use;
   logic              md_stall;
   logic              ld_stall;
   logic              kill;

   // One comparator per EX source operand
   for (genvar i = 0; i < NSRC; i++) begin : g_src
      hazard_fwd_unit_fwd_src_sel #(
         .REG_AW (REG_AW)
      ) u_sel (
         .ex_rs        (hz.ex_rs[i*REG_AW +: REG_AW]),
         .imm_sel      (hz.ex_imm_sel[i]),
         .mem_rd       (hz.mem_rd),
         .mem_regwrite (hz.mem_regwrite),
         .wb_rd        (hz.wb_rd),
         .wb_regwrite  (hz.wb_regwrite),
         .sel          (fwd_raw[2*i +: 2])
      );
   end

   // ID-side source matching: WB bypass selects and the load-use source hit
   always_comb begin
      id_wb_raw  = '0;
      ld_src_hit = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if ((WB_BYPASS != 0) && hz.id_rs_used[i] && hz.wb_regwrite &&
             (hz.wb_rd != '0) && (hz.wb_rd == hz.id_rs[i*REG_AW +: REG_AW])) begin
            id_wb_raw[i] = 1'b1;
         end
         if (hz.id_rs_used[i] && (hz.id_rs[i*REG_AW +: REG_AW] == hz.ex_rd)) begin
            ld_src_hit = 1'b1;
         end
      end
   end

   assign load_use = hz.id_valid && hz.ex_memread && hz.ex_regwrite &&
                     (hz.ex_rd != '0) && ld_src_hit;

   // Redirect overrides every stall; reset silences everything.
   assign kill     = rst || hz.redirect;
   assign md_stall = !kill && (((state == RUN) && hz.ex_md_start) ||
                               ((state == MD_BUSY) && (cnt != '0)));
   assign ld_stall = !kill && !md_stall && load_use;

   assign hz.fwd_sel    = rst ? '0 : fwd_raw;
   assign hz.id_fwd_wb  = rst ? '0 : id_wb_raw;
   assign hz.stall_if   = md_stall || ld_stall;
   assign hz.stall_id   = md_stall || ld_stall;
   assign hz.stall_ex   = md_stall;
   assign hz.bubble_ex  = ld_stall || (!rst && hz.redirect);
   assign hz.bubble_mem = md_stall;
   assign hz.flush_id   = !rst && hz.redirect;
   assign hz.md_busy    = !rst && (state == MD_BUSY);

   assign hz.ld_stall_cnt = ld_cnt;
   assign hz.md_stall_cnt = md_cnt;

   // Multi-cycle op FSM, its latency counter and the saturating perf counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= RUN;
         cnt    <= '0;
         ld_cnt <= '0;
         md_cnt <= '0;
      end else begin
         if (hz.redirect) begin
            state <= RUN;
            cnt   <= '0;
         end else begin
            case (state)
               RUN: begin
                  if (hz.ex_md_start) begin
                     state <= MD_BUSY;
                     cnt   <= CNT_INIT;
                  end
               end
               MD_BUSY: begin
                  if (cnt != '0) begin
                     cnt <= cnt - CNT_W'(1);
                  end else begin
                     state <= RUN;
                  end
               end
            endcase
         end
         if (ld_stall && (ld_cnt != '1)) begin
            ld_cnt <= ld_cnt + PERF_W'(1);
         end
         if (md_stall && (md_cnt != '1)) begin
            md_cnt <= md_cnt + PERF_W'(1);
         end
      end
   end

endmodule : hazard_fwd_unit

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: hand-computed literal checks for each
// scenario plus a cycle-by-cycle comparison against a behavioural model.
module tb_hazard_fwd_unit;

   localparam int REG_AW    = 5;
   localparam int NSRC      = 2;
   localparam int MD_LAT    = 4;
   localparam int WB_BYPASS = 1;
   localparam int PERF_W    = 4;
   localparam int PERF_MAX  = (1 << PERF_W) - 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard_fwd_unit_if #(.REG_AW(REG_AW), .NSRC(NSRC), .PERF_W(PERF_W)) hz ();

   hazard_fwd_unit #(
      .REG_AW    (REG_AW),
      .NSRC      (NSRC),
      .MD_LAT    (MD_LAT),
      .WB_BYPASS (WB_BYPASS),
      .PERF_W    (PERF_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // ---------------- scoreboard compare ----------------
   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      hz.id_valid     = 1'b0;
      hz.id_rs        = '0;
      hz.id_rs_used   = '0;
      hz.ex_rs        = '0;
      hz.ex_imm_sel   = '0;
      hz.ex_rd        = '0;
      hz.ex_regwrite  = 1'b0;
      hz.ex_memread   = 1'b0;
      hz.ex_md_start  = 1'b0;
      hz.mem_rd       = '0;
      hz.mem_regwrite = 1'b0;
      hz.wb_rd        = '0;
      hz.wb_regwrite  = 1'b0;
      hz.redirect     = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic at_sample();
      @(negedge clk);
   endtask

   task automatic set_fwd(input int rs0, input int rs1, input logic [1:0] imm,
                          input int mrd, input logic mwe, input int wrd, input logic wwe);
      hz.ex_rs        = {REG_AW'(rs1), REG_AW'(rs0)};
      hz.ex_imm_sel   = imm;
      hz.mem_rd       = REG_AW'(mrd);
      hz.mem_regwrite = mwe;
      hz.wb_rd        = REG_AW'(wrd);
      hz.wb_regwrite  = wwe;
   endtask

   // ---------------- behavioural model ----------------
   // m_occ: EX cycles still to be spent by the in-flight multi-cycle op (0 = none)
   int m_occ = 0;
   int m_ld  = 0;
   int m_md  = 0;
   int ers, irs;
   logic [2*NSRC-1:0] e_fwd;
   logic [NSRC-1:0]   e_idw;
   bit lu, md_on, ld_on;

   function automatic int src_of(input logic [NSRC*REG_AW-1:0] v, input int i);
      return int'(v[i*REG_AW +: REG_AW]);
   endfunction

   always @(negedge clk) begin
      e_fwd = '0;
      e_idw = '0;
      lu    = 1'b0;
      md_on = 1'b0;
      ld_on = 1'b0;
      if (!rst) begin
         for (int i = 0; i < NSRC; i++) begin
            ers = src_of(hz.ex_rs, i);
            irs = src_of(hz.id_rs, i);
            if (hz.ex_imm_sel[i] == 1'b0) begin
               if (hz.mem_regwrite && hz.mem_rd != 0 && int'(hz.mem_rd) == ers) e_fwd[2*i +: 2] = 2'b10;
               else if (hz.wb_regwrite && hz.wb_rd != 0 && int'(hz.wb_rd) == ers) e_fwd[2*i +: 2] = 2'b01;
            end
            if (WB_BYPASS != 0 && hz.id_rs_used[i] && hz.wb_regwrite && hz.wb_rd != 0 &&
                int'(hz.wb_rd) == irs) e_idw[i] = 1'b1;
            if (hz.id_rs_used[i] && int'(hz.ex_rd) == irs) lu = 1'b1;
         end
         lu    = lu && hz.id_valid && hz.ex_memread && hz.ex_regwrite && hz.ex_rd != 0;
         md_on = !hz.redirect && ((m_occ == 0 && hz.ex_md_start) || m_occ > 1);
         ld_on = !hz.redirect && !md_on && lu;
      end
      cmp("cyc_fwd_sel",    hz.fwd_sel,    e_fwd);
      cmp("cyc_id_fwd_wb",  hz.id_fwd_wb,  e_idw);
      cmp("cyc_stall_if",   hz.stall_if,   md_on || ld_on);
      cmp("cyc_stall_id",   hz.stall_id,   md_on || ld_on);
      cmp("cyc_stall_ex",   hz.stall_ex,   md_on);
      cmp("cyc_bubble_ex",  hz.bubble_ex,  ld_on || (!rst && hz.redirect));
      cmp("cyc_bubble_mem", hz.bubble_mem, md_on);
      cmp("cyc_flush_id",   hz.flush_id,   !rst && hz.redirect);
      cmp("cyc_md_busy",    hz.md_busy,    !rst && m_occ > 0);
      cmp("cyc_ld_cnt",     hz.ld_stall_cnt, m_ld);
      cmp("cyc_md_cnt",     hz.md_stall_cnt, m_md);
      // advance to the state the next clock edge will produce
      if (rst) begin
         m_occ = 0;
         m_ld  = 0;
         m_md  = 0;
      end else begin
         if (hz.redirect)          m_occ = 0;
         else if (m_occ > 0)       m_occ = m_occ - 1;
         else if (hz.ex_md_start)  m_occ = MD_LAT - 1;
         if (ld_on && m_ld < PERF_MAX) m_ld++;
         if (md_on && m_md < PERF_MAX) m_md++;
      end
   end

   // ---------------- directed forwarding table ----------------
   int         t_rs0 [6] = '{3, 3, 8, 31, 12, 7};
   int         t_rs1 [6] = '{3, 4, 9, 0, 12, 2};
   logic [1:0] t_imm [6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
   int         t_mrd [6] = '{3, 3, 8, 31, 0, 2};
   logic       t_mwe [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   int         t_wrd [6] = '{3, 4, 9, 0, 12, 7};
   logic       t_wwe [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [3:0] t_exp [6] = '{4'b1010, 4'b0100, 4'b0100, 4'b0010, 4'b0001, 4'b1000};

   // ---------------- stimulus ----------------
   initial begin
      clear_inputs();
      // reset with hazards present: every control output must stay low
      next_cycle();
      set_fwd(5, 0, 2'b00, 5, 1'b1, 0, 1'b0);
      hz.redirect    = 1'b1;
      hz.ex_md_start = 1'b1;
      at_sample();
      cmp("rst_fwd_sel",  hz.fwd_sel,  4'b0000);
      cmp("rst_flush_id", hz.flush_id, 1'b0);
      cmp("rst_stall_ex", hz.stall_ex, 1'b0);
      cmp("rst_ld_cnt",   hz.ld_stall_cnt, 0);
      next_cycle();
      rst = 1'b0;
      clear_inputs();

      // T1: MEM beats WB for src0; WB bypass to ID src0
      next_cycle();
      set_fwd(5, 9, 2'b00, 5, 1'b1, 5, 1'b1);
      hz.id_rs      = {5'd0, 5'd5};
      hz.id_rs_used = 2'b01;
      at_sample();
      cmp("t1_fwd_sel",   hz.fwd_sel,   4'b0010);
      cmp("t1_id_fwd_wb", hz.id_fwd_wb, 2'b01);
      next_cycle();
      hz.mem_rd = 5'd4;
      at_sample();
      cmp("t1_wb_only", hz.fwd_sel[1:0], 2'b01);

      // T2: x0 never forwards; immediate operand never forwards
      next_cycle();
      clear_inputs();
      set_fwd(0, 0, 2'b00, 0, 1'b0, 0, 1'b1);
      at_sample();
      cmp("t2_x0", hz.fwd_sel[3:2], 2'b00);
      next_cycle();
      set_fwd(6, 6, 2'b10, 6, 1'b1, 0, 1'b0);
      at_sample();
      cmp("t2_imm", hz.fwd_sel, 4'b0010);

      // forwarding table
      for (int k = 0; k < 6; k++) begin
         next_cycle();
         set_fwd(t_rs0[k], t_rs1[k], t_imm[k], t_mrd[k], t_mwe[k], t_wrd[k], t_wwe[k]);
         at_sample();
         cmp($sformatf("tbl%0d_fwd_sel", k), hz.fwd_sel, t_exp[k]);
      end

      // T3: load-use on src1; no stall while that source is unused
      next_cycle();
      clear_inputs();
      hz.id_valid    = 1'b1;
      hz.id_rs       = {5'd7, 5'd2};
      hz.id_rs_used  = 2'b01;
      hz.ex_memread  = 1'b1;
      hz.ex_regwrite = 1'b1;
      hz.ex_rd       = 5'd7;
      at_sample();
      cmp("t3_unused_src", hz.stall_if, 1'b0);
      next_cycle();
      hz.id_rs_used = 2'b10;
      at_sample();
      cmp("t3_stall_if",  hz.stall_if,  1'b1);
      cmp("t3_stall_id",  hz.stall_id,  1'b1);
      cmp("t3_bubble_ex", hz.bubble_ex, 1'b1);
      cmp("t3_stall_ex",  hz.stall_ex,  1'b0);
      next_cycle();
      hz.ex_memread  = 1'b0;
      hz.ex_regwrite = 1'b0;
      hz.ex_rd       = '0;
      at_sample();
      cmp("t3_released", hz.stall_if, 1'b0);
      cmp("t3_ld_cnt",   hz.ld_stall_cnt, 1);

      // T4: multi-cycle op, load-use ignored while the md stall is active
      next_cycle();
      clear_inputs();
      hz.ex_md_start = 1'b1;
      at_sample();
      cmp("t4_c1_stall_ex", hz.stall_ex,   1'b1);
      cmp("t4_c1_bub_mem",  hz.bubble_mem, 1'b1);
      cmp("t4_c1_busy",     hz.md_busy,    1'b0);
      next_cycle();
      hz.id_valid    = 1'b1;
      hz.id_rs       = {5'd0, 5'd9};
      hz.id_rs_used  = 2'b01;
      hz.ex_memread  = 1'b1;
      hz.ex_regwrite = 1'b1;
      hz.ex_rd       = 5'd9;
      at_sample();
      cmp("t4_c2_stall_ex", hz.stall_ex,  1'b1);
      cmp("t4_c2_busy",     hz.md_busy,   1'b1);
      cmp("t4_c2_no_ldbub", hz.bubble_ex, 1'b0);
      next_cycle();
      hz.id_valid   = 1'b0;
      hz.ex_memread = 1'b0;
      at_sample();
      cmp("t4_c3_stall_ex", hz.stall_ex, 1'b1);
      next_cycle();
      at_sample();
      cmp("t4_c4_stall_ex", hz.stall_ex, 1'b0);
      cmp("t4_c4_busy",     hz.md_busy,  1'b1);
      next_cycle();
      clear_inputs();
      at_sample();
      cmp("t4_done_busy", hz.md_busy,      1'b0);
      cmp("t4_md_cnt",    hz.md_stall_cnt, 3);
      cmp("t4_ld_cnt",    hz.ld_stall_cnt, 1);

      // T5: redirect in the second MD_BUSY cycle aborts the op
      next_cycle();
      hz.ex_md_start = 1'b1;
      next_cycle();
      next_cycle();
      hz.redirect = 1'b1;
      at_sample();
      cmp("t5_stall_ex",  hz.stall_ex,  1'b0);
      cmp("t5_stall_if",  hz.stall_if,  1'b0);
      cmp("t5_flush_id",  hz.flush_id,  1'b1);
      cmp("t5_bubble_ex", hz.bubble_ex, 1'b1);
      next_cycle();
      clear_inputs();
      at_sample();
      cmp("t5_run_busy", hz.md_busy,      1'b0);
      cmp("t5_md_cnt",   hz.md_stall_cnt, 5);

      // T6: saturate md counter (5 + 4*3 -> 15), then reset mid MD_BUSY
      for (int op = 0; op < 4; op++) begin
         next_cycle();
         hz.ex_md_start = 1'b1;
         repeat (MD_LAT - 1) next_cycle();
         next_cycle();
         hz.ex_md_start = 1'b0;
      end
      at_sample();
      cmp("t6_md_sat", hz.md_stall_cnt, 15);
      next_cycle();
      hz.ex_md_start = 1'b1;
      next_cycle();
      at_sample();
      cmp("t6_md_hold", hz.md_stall_cnt, 15);
      cmp("t6_busy",    hz.md_busy,      1'b1);
      next_cycle();
      rst = 1'b1;
      set_fwd(5, 5, 2'b00, 5, 1'b1, 5, 1'b1);
      at_sample();
      cmp("t6_rst_stall_ex", hz.stall_ex,   1'b0);
      cmp("t6_rst_stall_if", hz.stall_if,   1'b0);
      cmp("t6_rst_bub_mem",  hz.bubble_mem, 1'b0);
      cmp("t6_rst_busy",     hz.md_busy,    1'b0);
      cmp("t6_rst_fwd",      hz.fwd_sel,    4'b0000);
      next_cycle();
      rst = 1'b0;
      clear_inputs();
      at_sample();
      cmp("t6_post_busy",     hz.md_busy,      1'b0);
      cmp("t6_post_stall_ex", hz.stall_ex,     1'b0);
      cmp("t6_post_md_cnt",   hz.md_stall_cnt, 0);
      cmp("t6_post_ld_cnt",   hz.ld_stall_cnt, 0);
      next_cycle();
      at_sample();
      cmp("t6_post2_busy", hz.md_busy, 1'b0);

      // ---------------- final report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // hard time bound so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_hazard_fwd_unit
